// File: rtl/char_rom_pkg.sv
// +----------------------------------------------------------------------------+
// | char_rom_pkg                                                               |
// | Shared widths, ROM latency and owner tag type for the character-ROM        |
// | arbiter. Define CHARROM_OREG_EN when the ROM is built with its output      |
// | register.                                                                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package char_rom_pkg;

  localparam int CHAR_W       = 8;
  localparam int ROW_W        = 3;
  localparam int DATA_W       = 8;
  localparam int ROM_ADDR_W   = CHAR_W + ROW_W;
  localparam int STARVE_LIMIT = 15;
  localparam int STARVE_W     = 4;

`ifdef CHARROM_OREG_EN
  localparam int ROM_LAT = 2;
`else
  localparam int ROM_LAT = 1;
`endif

  typedef enum logic {
    OWN_DISP = 1'b0,
    OWN_HOST = 1'b1
  } owner_t;

endpackage

`default_nettype wire

// File: rtl/rom_tag_pipe.sv
// +----------------------------------------------------------------------------+
// | rom_tag_pipe                                                               |
// | Valid + owner shift register that tracks reads in flight through the ROM.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rom_tag_pipe
  import char_rom_pkg::*;
#(
  parameter int DEPTH = ROM_LAT
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   in_valid,
  input  owner_t in_owner,
  output logic   out_valid,
  output owner_t out_owner
);

  logic [DEPTH-1:0] valid_d, valid_q;
  logic [DEPTH-1:0] owner_d, owner_q;

  always_comb begin
    valid_d    = valid_q;
    owner_d    = owner_q;
    valid_d[0] = in_valid;
    owner_d[0] = in_owner;
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      owner_d[i] = owner_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      owner_q <= '0;
    end else begin
      valid_q <= valid_d;
      owner_q <= owner_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_owner = owner_t'(owner_q[DEPTH-1]);

endmodule

`default_nettype wire

// File: rtl/char_rom_arbiter.sv
// +----------------------------------------------------------------------------+
// | char_rom_arbiter                                                           |
// | Shares the single-port glyph ROM between display scanout (absolute         |
// | priority) and a host reader; CHARROM_OREG_EN selects the registered ROM.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module char_rom_arbiter
  import char_rom_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  disp_req,
  input  logic [CHAR_W-1:0]     disp_char,
  input  logic [ROW_W-1:0]      disp_row,
  output logic                  disp_rvalid,
  output logic [DATA_W-1:0]     disp_rdata,
  input  logic                  host_req,
  input  logic [CHAR_W-1:0]     host_char,
  input  logic [ROW_W-1:0]      host_row,
  output logic                  host_ack,
  output logic                  host_rvalid,
  output logic [DATA_W-1:0]     host_rdata,
  output logic                  host_starved,
  output logic                  rom_ce,
  output logic                  rom_oce,
  output logic                  rom_reset,
  output logic [ROM_ADDR_W-1:0] rom_ad,
  input  logic [DATA_W-1:0]     rom_dout
);

  localparam logic [STARVE_W-1:0] c_starve_limit = STARVE_W'(STARVE_LIMIT);
  localparam logic [STARVE_W-1:0] c_wait_max     = '1;

  logic                  grant_host;
  logic                  issue;
  logic [ROM_ADDR_W-1:0] rom_ad_d, rom_ad_q;
  logic                  rom_ce_d, rom_ce_q;
  logic                  rom_oce_d, rom_oce_q;
  logic                  host_ack_d, host_ack_q;
  logic                  issue_d, issue_q;
  owner_t                issue_owner_d, issue_owner_q;
  logic [STARVE_W-1:0]   wait_cnt_d, wait_cnt_q;
  logic                  host_starved_d, host_starved_q;
  logic                  tag_valid;
  owner_t                tag_owner;

  always_comb begin
    // The ack cycle blocks a re-grant so a level-held host_req is not double-counted.
    grant_host    = !disp_req && host_req && !host_ack_q;
    issue         = disp_req || grant_host;
    rom_ad_d      = rom_ad_q;
    if (disp_req) begin
      rom_ad_d = {disp_char, disp_row};
    end else if (grant_host) begin
      rom_ad_d = {host_char, host_row};
    end
    issue_d       = issue;
    issue_owner_d = grant_host ? OWN_HOST : OWN_DISP;
    host_ack_d    = grant_host;
`ifdef CHARROM_OREG_EN
    rom_ce_d      = issue || issue_q;
    rom_oce_d     = issue_q;
`else
    rom_ce_d      = issue;
    rom_oce_d     = 1'b0;
`endif
    wait_cnt_d    = '0;
    if (host_req && !grant_host) begin
      wait_cnt_d = (wait_cnt_q == c_wait_max) ? wait_cnt_q : wait_cnt_q + 1'b1;
    end
    host_starved_d = (wait_cnt_d >= c_starve_limit);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_ad_q       <= '0;
      rom_ce_q       <= 1'b0;
      rom_oce_q      <= 1'b0;
      host_ack_q     <= 1'b0;
      issue_q        <= 1'b0;
      issue_owner_q  <= OWN_DISP;
      wait_cnt_q     <= '0;
      host_starved_q <= 1'b0;
    end else begin
      rom_ad_q       <= rom_ad_d;
      rom_ce_q       <= rom_ce_d;
      rom_oce_q      <= rom_oce_d;
      host_ack_q     <= host_ack_d;
      issue_q        <= issue_d;
      issue_owner_q  <= issue_owner_d;
      wait_cnt_q     <= wait_cnt_d;
      host_starved_q <= host_starved_d;
    end
  end

  rom_tag_pipe #(
    .DEPTH(ROM_LAT)
  ) u_tag_pipe (
    .clk      (clk),
    .reset    (reset),
    .in_valid (issue_q),
    .in_owner (issue_owner_q),
    .out_valid(tag_valid),
    .out_owner(tag_owner)
  );

  assign disp_rvalid  = tag_valid && (tag_owner == OWN_DISP);
  assign host_rvalid  = tag_valid && (tag_owner == OWN_HOST);
  assign disp_rdata   = rom_dout;
  assign host_rdata   = rom_dout;
  assign host_ack     = host_ack_q;
  assign host_starved = host_starved_q;
  assign rom_ce       = rom_ce_q;
  assign rom_oce      = rom_oce_q;
  assign rom_ad       = rom_ad_q;
  assign rom_reset    = reset;

endmodule

`default_nettype wire

// File: tb/tb_char_rom_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_char_rom_arbiter                                                        |
// | Self-checking bench for char_rom_arbiter with a behavioural glyph ROM.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_char_rom_arbiter;

`ifdef CHARROM_OREG_EN
  localparam int LAT  = 2;
  localparam bit OREG = 1'b1;
`else
  localparam int LAT  = 1;
  localparam bit OREG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        disp_req, host_req;
  logic [7:0]  disp_char, host_char;
  logic [2:0]  disp_row, host_row;
  logic        disp_rvalid, host_rvalid, host_ack, host_starved;
  logic [7:0]  disp_rdata, host_rdata, rom_dout;
  logic        rom_ce, rom_oce, rom_reset;
  logic [10:0] rom_ad;

  always #5 clk = ~clk;

  char_rom_arbiter dut (
    .clk(clk), .reset(reset),
    .disp_req(disp_req), .disp_char(disp_char), .disp_row(disp_row),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .host_req(host_req), .host_char(host_char), .host_row(host_row),
    .host_ack(host_ack), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .host_starved(host_starved),
    .rom_ce(rom_ce), .rom_oce(rom_oce), .rom_reset(rom_reset),
    .rom_ad(rom_ad), .rom_dout(rom_dout)
  );

  function automatic logic [7:0] rom_byte(input logic [10:0] a);
    logic [15:0] t;
    t = 16'(a) * 16'd37 + 16'h5A;
    return t[7:0] ^ a[10:3];
  endfunction

  // Behavioural glyph ROM, optionally with its output register.
  logic [7:0] rom_arr;
  always @(posedge clk or posedge rom_reset) begin
    if (rom_reset) begin
      rom_arr  <= 8'h00;
      rom_dout <= 8'h00;
    end else begin
`ifdef CHARROM_OREG_EN
      if (rom_ce) rom_arr <= rom_byte(rom_ad);
      if (rom_ce && rom_oce) rom_dout <= rom_arr;
`else
      if (rom_ce) rom_dout <= rom_byte(rom_ad);
`endif
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: grants, expected address and scheduled returns per cycle.
  int          cyc;
  bit          ack_last, issued_prev;
  int          waits;
  logic [10:0] m_ad;
  bit          sv[8], sh[8];
  logic [7:0]  sdat[8];
  bit          e_ack, e_ce, e_oce, e_rvd, e_rvh, e_starved;
  logic [7:0]  e_data;

  task automatic model_reset();
    ack_last = 0; issued_prev = 0; waits = 0; m_ad = '0;
    e_ack = 0; e_ce = 0; e_oce = 0; e_rvd = 0; e_rvh = 0; e_starved = 0; e_data = '0;
    for (int i = 0; i < 8; i++) begin sv[i] = 0; sh[i] = 0; sdat[i] = '0; end
  endtask

  task automatic model_step();
    bit gd, gh, iss;
    int slot;
    cyc++;
    gd  = disp_req;
    gh  = !disp_req && host_req && !ack_last;
    iss = gd || gh;
    if (gd) m_ad = {disp_char, disp_row};
    else if (gh) m_ad = {host_char, host_row};
    slot   = cyc % 8;
    e_rvd  = sv[slot] && !sh[slot];
    e_rvh  = sv[slot] && sh[slot];
    e_data = sdat[slot];
    sv[slot] = 0;
    if (iss) begin
      sv[(cyc + LAT) % 8]   = 1;
      sh[(cyc + LAT) % 8]   = gh;
      sdat[(cyc + LAT) % 8] = rom_byte(m_ad);
    end
    e_ack       = gh;
    ack_last    = gh;
    e_ce        = iss || (OREG && issued_prev);
    e_oce       = OREG && issued_prev;
    issued_prev = iss;
    waits       = (host_req && !gh) ? waits + 1 : 0;
    e_starved   = (waits >= 15);
  endtask

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_all();
    check1("host_ack",     32'(host_ack),     32'(e_ack));
    check1("rom_ad",       32'(rom_ad),       32'(m_ad));
    check1("rom_ce",       32'(rom_ce),       32'(e_ce));
    check1("rom_oce",      32'(rom_oce),      32'(e_oce));
    check1("disp_rvalid",  32'(disp_rvalid),  32'(e_rvd));
    check1("host_rvalid",  32'(host_rvalid),  32'(e_rvh));
    check1("host_starved", 32'(host_starved), 32'(e_starved));
    check1("rom_reset",    32'(rom_reset),    32'd0);
    if (e_rvd) check1("disp_rdata", 32'(disp_rdata), 32'(e_data));
    if (e_rvh) check1("host_rdata", 32'(host_rdata), 32'(e_data));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input bit dr, input logic [7:0] dc, input logic [2:0] drw,
                       input bit hr, input logic [7:0] hc, input logic [2:0] hrw);
    disp_req = dr; disp_char = dc; disp_row = drw;
    host_req = hr; host_char = hc; host_row = hrw;
  endtask

  task automatic check_reset_outputs(input string tag);
    check1({tag, "_disp_rvalid"},  32'(disp_rvalid),  32'd0);
    check1({tag, "_host_rvalid"},  32'(host_rvalid),  32'd0);
    check1({tag, "_host_ack"},     32'(host_ack),     32'd0);
    check1({tag, "_host_starved"}, 32'(host_starved), 32'd0);
    check1({tag, "_rom_ce"},       32'(rom_ce),       32'd0);
    check1({tag, "_rom_oce"},      32'(rom_oce),      32'd0);
    check1({tag, "_rom_ad"},       32'(rom_ad),       32'd0);
    check1({tag, "_rom_reset"},    32'(rom_reset),    32'd1);
  endtask

  typedef struct {
    bit          dreq;
    logic [7:0]  dch;
    logic [2:0]  drow;
    bit          hreq;
    logic [7:0]  hch;
    logic [2:0]  hrow;
    bit          x_ack;
    logic [10:0] x_ad;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int acks, hrvs;
    tbl[0] = '{1, 8'h41, 3'd3, 0, 8'h00, 3'd0, 0, 11'h20B};
    tbl[1] = '{0, 8'h00, 3'd0, 0, 8'h00, 3'd0, 0, 11'h20B};
    tbl[2] = '{1, 8'h10, 3'd1, 1, 8'h22, 3'd5, 0, 11'h081};
    tbl[3] = '{0, 8'h00, 3'd0, 1, 8'h22, 3'd5, 1, 11'h115};
    tbl[4] = '{0, 8'h00, 3'd0, 1, 8'h22, 3'd5, 0, 11'h115};
    tbl[5] = '{0, 8'h00, 3'd0, 1, 8'h7F, 3'd7, 1, 11'h3FF};
    tbl[6] = '{0, 8'h00, 3'd0, 0, 8'h00, 3'd0, 0, 11'h3FF};
    tbl[7] = '{1, 8'h00, 3'd0, 1, 8'h33, 3'd2, 0, 11'h000};
    tbl[8] = '{1, 8'hFF, 3'd7, 1, 8'h33, 3'd2, 0, 11'h7FF};
    tbl[9] = '{0, 8'h00, 3'd0, 0, 8'h33, 3'd2, 0, 11'h7FF};

    cyc = 0;
    reset = 1'b1;
    drive(0, 8'h00, 3'd0, 0, 8'h00, 3'd0);
    model_reset();
    @(negedge clk); @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    // Table vectors: arbitration, hold, ack-cycle blocking, early host drop.
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].dreq, tbl[i].dch, tbl[i].drow, tbl[i].hreq, tbl[i].hch, tbl[i].hrow);
      tick();
      check1("tbl_ack", 32'(host_ack), 32'(tbl[i].x_ack));
      check1("tbl_ad",  32'(rom_ad),   32'(tbl[i].x_ad));
    end
    drive(0, 8'h00, 3'd0, 0, 8'h00, 3'd0);
    repeat (3) tick();

    // Single display read: address next cycle, data after ROM latency.
    drive(1, 8'h41, 3'd3, 0, 8'h00, 3'd0);
    tick();
    check1("single_ad", 32'(rom_ad), 32'h20B);
    drive(0, 8'h00, 3'd0, 0, 8'h00, 3'd0);
    for (int k = 1; k <= LAT; k++) begin
      tick();
      check1("single_rvalid", 32'(disp_rvalid), 32'(k == LAT));
      if (k == LAT) check1("single_rdata", 32'(disp_rdata), 32'(rom_byte(11'h20B)));
    end
    repeat (2) tick();

    // Starvation: 20 display cycles with the host waiting.
    for (int i = 1; i <= 20; i++) begin
      drive(1, 8'($urandom), 3'($urandom), 1, 8'h5C, 3'd4);
      tick();
      check1("starve_level", 32'(host_starved), 32'(i >= 15));
    end
    drive(0, 8'h00, 3'd0, 1, 8'h5C, 3'd4);
    tick();
    check1("starve_ack",   32'(host_ack),     32'd1);
    check1("starve_clear", 32'(host_starved), 32'd0);
    drive(0, 8'h00, 3'd0, 0, 8'h00, 3'd0);
    repeat (LAT + 2) tick();

    // Host request held across its ack: exactly one grant and one return.
    acks = 0; hrvs = 0;
    drive(0, 8'h00, 3'd0, 1, 8'h7F, 3'd7);
    tick();
    check1("held_ad", 32'(rom_ad), 32'h3FF);
    acks += int'(host_ack); hrvs += int'(host_rvalid);
    tick();
    acks += int'(host_ack); hrvs += int'(host_rvalid);
    drive(0, 8'h00, 3'd0, 0, 8'h00, 3'd0);
    repeat (LAT + 2) begin
      tick();
      acks += int'(host_ack); hrvs += int'(host_rvalid);
    end
    check1("held_acks",   32'(acks), 32'd1);
    check1("held_rvalid", 32'(hrvs), 32'd1);

    // Reset between issue and return.
    drive(1, 8'h12, 3'd6, 1, 8'h34, 3'd1);
    tick();
    drive(0, 8'h00, 3'd0, 0, 8'h00, 3'd0);
    #1 reset = 1'b1;
    #1 check_reset_outputs("midreset");
    model_reset();
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check_reset_outputs("held_reset");
    reset = 1'b0;
    repeat (LAT + 3) tick();

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 3) == 0, 8'($urandom), 3'($urandom),
            ($urandom % 4) != 0, 8'($urandom), 3'($urandom));
      tick();
    end
    drive(0, 8'h00, 3'd0, 0, 8'h00, 3'd0);
    repeat (LAT + 2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
